// File: rtl/normalizador_secuencial.sv
// -----------------------------------------------------------------------------
// normalizador_secuencial
//
// Post-addition stage of the single-precision floating-point adder. It takes
// the raw sum from the mantissa adder/subtractor, normalizes it one left shift
// per clock, rounds to nearest-even and packs an IEEE-754 word.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   in_valid       operand valid
//   in_ready       block can accept (idle and not in reset)
//   Suma_Mantissa  raw sum: [26] carry, [25] hidden, [24:2] fraction,
//                  [1] guard, [0] round
//   Exp_comun      biased common exponent of the operands
//   Signo          sign of the result
//   out_valid      result valid
//   out_ready      consumer accepts the result
//   Resultado      {sign, exponent, fraction}
//   Overflow       result rounded to infinity
//   Cero           result is +/-0
//   Subnormal      exponent field 0 with a nonzero fraction
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer keeps valid and its data stable until that edge;
// ready may be deasserted at any time. Only one operation is in flight: a new
// operand is accepted only in IDLE, never in the cycle a result is taken.
// -----------------------------------------------------------------------------
module normalizador_secuencial #(
  parameter int ANCHO_EXP  = 8,
  parameter int ANCHO_MANT = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ANCHO_MANT+2:0]          Suma_Mantissa,
  input  logic [ANCHO_EXP-1:0]           Exp_comun,
  input  logic                           Signo,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ANCHO_EXP+ANCHO_MANT-1:0] Resultado,
  output logic                           Overflow,
  output logic                           Cero,
  output logic                           Subnormal
);

  // Working mantissa: carry, hidden, fraction, guard, round.
  localparam int WM = ANCHO_MANT + 3;
  // Exponent register has two extra bits so carries past the maximum
  // (exponent 255 + adjust + rounding carry) never wrap.
  localparam int WE = ANCHO_EXP + 2;
  localparam int WF = ANCHO_MANT - 1;
  localparam int WR = ANCHO_EXP + ANCHO_MANT;
  localparam int WC = $clog2(ANCHO_MANT + 1);

  localparam logic signed [WE-1:0] EXP_UNO  = WE'(1);
  localparam logic signed [WE-1:0] EXP_MAX  = WE'((1 << ANCHO_EXP) - 1);
  localparam logic [WC-1:0]        MAX_DESP = WC'(ANCHO_MANT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AJUSTE   = 3'd1,
    NORM     = 3'd2,
    REDONDEO = 3'd3,
    SALIDA   = 3'd4
  } estado_t;

  // State and datapath registers
  estado_t               estado;
  logic [WM-1:0]         man;
  logic                  sticky;
  logic signed [WE-1:0]  exp_r;
  logic                  sign_r;
  logic [WC-1:0]         desp;

  // Next-state values
  estado_t               estado_n;
  logic [WM-1:0]         man_n;
  logic                  sticky_n;
  logic signed [WE-1:0]  exp_n;
  logic                  sign_n;
  logic [WC-1:0]         desp_n;
  logic                  out_valid_n;
  logic [WR-1:0]         resultado_n;
  logic                  overflow_n;
  logic                  cero_n;
  logic                  subnormal_n;

  // Rounding datapath
  logic                  round_up;
  logic [WM-3:0]         alta;      // man[WM-1:2] plus the rounding increment
  logic                  hid_rnd;
  logic [WF-1:0]         frac_rnd;
  logic signed [WE-1:0]  exp_rnd;
  logic [ANCHO_EXP-1:0]  campo_exp;

  assign in_ready = (estado == IDLE) && !rst;

  // Round to nearest-even on the guard/round/sticky bits. The increment is
  // applied at bit 2 (LSB of the fraction), so only the upper part of the
  // mantissa takes part in the add. A carry out of the hidden bit renormalizes
  // by one right shift; the bit dropped there cannot matter any more.
  always_comb begin
    round_up  = man[1] & (man[0] | sticky | man[2]);
    alta      = man[WM-1:2] + {{(WM-3){1'b0}}, round_up};
    hid_rnd   = alta[WF];
    frac_rnd  = alta[WF-1:0];
    exp_rnd   = exp_r;
    if (alta[WM-3]) begin
      hid_rnd  = 1'b1;
      frac_rnd = alta[WF:1];
      exp_rnd  = exp_r + EXP_UNO;
    end
    // Without the hidden bit the number stays at the subnormal scale.
    campo_exp = hid_rnd ? exp_rnd[ANCHO_EXP-1:0] : '0;
  end

  // Next-state and output logic
  always_comb begin
    estado_n    = estado;
    man_n       = man;
    sticky_n    = sticky;
    exp_n       = exp_r;
    sign_n      = sign_r;
    desp_n      = desp;
    out_valid_n = out_valid;
    resultado_n = Resultado;
    overflow_n  = Overflow;
    cero_n      = Cero;
    subnormal_n = Subnormal;

    unique case (estado)
      IDLE: begin
        if (in_valid) begin
          man_n    = Suma_Mantissa;
          sticky_n = 1'b0;
          sign_n   = Signo;
          desp_n   = '0;
          // A zero biased exponent denotes subnormal operands, whose scale
          // is the same as exponent 1.
          exp_n    = (Exp_comun == '0) ? EXP_UNO : $signed({2'b00, Exp_comun});
          if (Suma_Mantissa == '0) begin
            estado_n    = SALIDA;
            out_valid_n = 1'b1;
            resultado_n = {Signo, {(WR-1){1'b0}}};
            overflow_n  = 1'b0;
            cero_n      = 1'b1;
            subnormal_n = 1'b0;
          end else begin
            estado_n = AJUSTE;
          end
        end
      end

      AJUSTE: begin
        // Addition carry: fold the dropped bit into sticky.
        if (man[WM-1]) begin
          sticky_n = sticky | man[0];
          man_n    = {1'b0, man[WM-1:1]};
          exp_n    = exp_r + EXP_UNO;
        end
        estado_n = NORM;
      end

      NORM: begin
        // Shift left until the hidden bit is set, but never below the
        // subnormal scale and never more than the significand width.
        if (!man[WM-2] && (exp_r > EXP_UNO) && (desp < MAX_DESP)) begin
          man_n  = {man[WM-2:0], 1'b0};
          exp_n  = exp_r - EXP_UNO;
          desp_n = desp + WC'(1);
        end else begin
          estado_n = REDONDEO;
        end
      end

      REDONDEO: begin
        out_valid_n = 1'b1;
        estado_n    = SALIDA;
        if (exp_rnd >= EXP_MAX) begin
          resultado_n = {sign_r, {ANCHO_EXP{1'b1}}, {WF{1'b0}}};
          overflow_n  = 1'b1;
          cero_n      = 1'b0;
          subnormal_n = 1'b0;
        end else begin
          resultado_n = {sign_r, campo_exp, frac_rnd};
          overflow_n  = 1'b0;
          cero_n      = !hid_rnd && (frac_rnd == '0);
          subnormal_n = !hid_rnd && (frac_rnd != '0);
        end
      end

      SALIDA: begin
        // Outputs hold until taken; they are cleared on the way back to IDLE.
        if (out_ready) begin
          estado_n    = IDLE;
          out_valid_n = 1'b0;
          resultado_n = '0;
          overflow_n  = 1'b0;
          cero_n      = 1'b0;
          subnormal_n = 1'b0;
        end
      end

      default: begin
        estado_n    = IDLE;
        out_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= IDLE;
      man       <= '0;
      sticky    <= 1'b0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      desp      <= '0;
      out_valid <= 1'b0;
      Resultado <= '0;
      Overflow  <= 1'b0;
      Cero      <= 1'b0;
      Subnormal <= 1'b0;
    end else begin
      estado    <= estado_n;
      man       <= man_n;
      sticky    <= sticky_n;
      exp_r     <= exp_n;
      sign_r    <= sign_n;
      desp      <= desp_n;
      out_valid <= out_valid_n;
      Resultado <= resultado_n;
      Overflow  <= overflow_n;
      Cero      <= cero_n;
      Subnormal <= subnormal_n;
    end
  end

endmodule

// File: doc/normalizador_secuencial.md
Name: normalizador_secuencial

Overview:
- Post-addition stage of the single-precision FP adder; sits downstream of the mantissa adder/subtractor, which consumes the aligned 26-bit mantissas and common exponent from the alignment stage.
- Takes the raw 27-bit sum (carry + hidden + 23 fraction + guard + round), the common exponent and the result sign.
- Normalizes iteratively, one left shift per cycle, then rounds to nearest-even and packs an IEEE-754 word.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- ANCHO_EXP, 8, exponent field width (verified only at default).
- ANCHO_MANT, 24, significand width including hidden bit (verified only at default).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept; = (estado==IDLE) && !rst.
- Suma_Mantissa  input  27  bit26 carry, bit25 hidden, [24:2] fraction, bit1 guard, bit0 round.
- Exp_comun  input  8  biased common exponent.
- Signo  input  1  result sign.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- Resultado  output  32  {sign, exp[7:0], frac[22:0]}.
- Overflow  output  1  result rounded to infinity.
- Cero  output  1  result is ±0.
- Subnormal  output  1  exponent field 0, fraction nonzero.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - estado=IDLE; out_valid=0; Resultado=0; Overflow=0; Cero=0; Subnormal=0; internal registers cleared.
  - Reset in any state aborts the operation with no output.
- Internal registers: man[26:0], sticky, signed 10-bit exp, sign.
- IDLE:
  - Accept when in_valid && in_ready.
  - Capture man, sign, sticky=0; exp=Exp_comun, with 0 captured as 1 (subnormal scale).
  - If Suma_Mantissa==0, go to SALIDA with Resultado={Signo,31'b0} and Cero=1. Otherwise go to AJUSTE.
- AJUSTE (1 cycle):
  - If man[26]: sticky|=man[0], man>>=1, exp+=1.
  - Go to NORM.
- NORM (one step per cycle):
  - If man[25]==0 && exp>1: man<<=1 (zero fill), exp-=1, stay in NORM.
  - Otherwise go to REDONDEO.
  - At most 24 shifts.
- REDONDEO (1 cycle):
  - G=man[1], R=man[0], S=sticky, LSB=man[2].
  - Round up iff G && (R||S||LSB); round-up adds 1 at bit 2.
  - If the add carries into bit26: shift right 1, exp+=1.
  - If exp>=255: Resultado={sign,8'hFF,23'b0}, Overflow=1.
  - Else exponent field = man[25] ? exp : 0; Subnormal=!man[25] && man[24:2]!=0; Cero=(man[25:2]==0).
  - Fraction = man[24:2]. Go to SALIDA.
- SALIDA:
  - out_valid=1; all outputs held stable until out_ready.
  - On out_valid && out_ready: out_valid=0 next edge, return to IDLE.
  - No same-cycle new accept.
- Latency: accept edge to out_valid = L+4 cycles, where L = left-shift count. Zero input: 1 cycle.
- Outputs other than in_ready are registered; flags are valid only while out_valid=1, and are cleared on the return to IDLE.

Test Plan:
- 1.0+1.0: Suma_Mantissa=27'h4000000, Exp_comun=127, Signo=0 -> Resultado=32'h40000000, out_valid 4 cycles after accept, all flags 0.
- Cancellation: 27'h0000004, exp 127 -> 23 shifts, Resultado=32'h34000000, latency 27; in_ready=0 throughout.
- Ties-to-even:
  - 27'h2000006, exp 127 -> 32'h3F800002.
  - 27'h2000002, exp 127 -> 32'h3F800000.
  - 27'h2000003, exp 127 -> 32'h3F800001.
- Overflow: 27'h4000000, exp 254, Signo=1 -> 32'hFF800000, Overflow=1.
- Zero and backpressure:
  - 27'h0, Signo=0 -> 32'h00000000, Cero=1, out_valid 1 cycle after accept.
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
  - Then out_ready=1 -> IDLE next cycle.
- Subnormal and reset:
  - 27'h0400000, exp 2 -> one shift, stop at exp 1, Resultado=32'h00200000, Subnormal=1.
  - Pulse rst during NORM of the cancellation case -> no out_valid, in_ready=1 the cycle after rst deasserts.
